spi_multidigit_pwm_ctrl: RTL and testbench

Command-driven controller that sits behind the SPI slave. It consumes the 4-bit nibble stream (data + single-cycle valid) and decodes it as framed commands. Commands write any of N_DIGITS multiplexed 7-segment digits, set the motor PWM duty with glitch-free period-boundary update, or blank the display. It replaces the single-digit hold register and the stub PWM tie-off at the top level.

---
 rtl/spi_multidigit_pwm_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_multidigit_pwm_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_multidigit_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_multidigit_pwm_ctrl
// Description : Framed command decoder behind the SPI slave nibble stream.
//               Writes N_DIGITS multiplexed active-low 7-segment digits,
//               sets the motor PWM duty (applied only at period wrap),
//               blanks the display, and flags protocol errors.
// Ports       : FPGA_clk          - system clock
//               FPGA_reset        - synchronous, active-low reset
//               spi_data[3:0]     - nibble from SPI slave (qualified by valid)
//               spi_valid         - single-cycle strobe per nibble
//               seg[6:0]          - active-low segments (g..a), scanned digit
//               digit_en_n[N-1:0] - active-low one-hot digit enable
//               motor_pwm_signal  - PWM output
//               duty_active[3:0]  - duty currently applied by the PWM
//               frame_err         - one-cycle pulse on protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module spi_multidigit_pwm_ctrl #(
    parameter int N_DIGITS       = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int PWM_PRESC_W    = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                FPGA_clk,
    input  logic                FPGA_reset,
    input  logic [3:0]          spi_data,
    input  logic                spi_valid,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] digit_en_n,
    output logic                motor_pwm_signal,
    output logic [3:0]          duty_active,
    output logic                frame_err
);

    localparam int c_idx_w  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int c_slot_w = $clog2(SCAN_DIV);
    localparam int c_to_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(N_DIGITS - 1);
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SCAN_DIV - 1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [N_DIGITS-1:0] c_en_rst    = ~(N_DIGITS'(1));
    localparam logic [3:0]          c_pwm_last  = 4'd14;
    localparam logic [6:0]          c_blank     = 7'h7F;

    localparam logic [1:0] c_op_digit = 2'b00;
    localparam logic [1:0] c_op_duty  = 2'b01;
    localparam logic [1:0] c_op_clear = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE         = 1'b0,
        S_WAIT_PAYLOAD = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_op, r_idx;
    logic [c_to_w-1:0]   r_tcnt;

    logic w_latch, w_clear, w_dig_we, w_duty_we, w_err;

    logic [6:0]          r_digit [N_DIGITS];
    logic [6:0]          w_dec;
    logic [3:0]          r_duty_shadow, r_duty_active;

    logic [PWM_PRESC_W-1:0] r_presc;
    logic [3:0]          r_pcnt;
    logic                w_tick, w_wrap, r_pwm;

    logic [c_slot_w-1:0] r_slot;
    logic [c_idx_w-1:0]  r_scan_idx;
    logic [6:0]          r_seg, w_seg_sel;
    logic [N_DIGITS-1:0] r_en, w_en_sel;
    logic                r_frame_err;

    // ---------------- command FSM ----------------
    always_ff @(posedge FPGA_clk) begin
        if (!FPGA_reset) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_clear     = 1'b0;
        w_dig_we    = 1'b0;
        w_duty_we   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (spi_valid) begin
                    case (spi_data[3:2])
                        c_op_digit, c_op_duty: begin
                            w_latch     = 1'b1;
                            w_state_nxt = S_WAIT_PAYLOAD;
                        end
                        c_op_clear: w_clear = 1'b1;
                        default:    w_err   = 1'b1;
                    endcase
                end
            end
            S_WAIT_PAYLOAD: begin
                // A valid nibble on the expiry cycle still wins over timeout.
                if (spi_valid) begin
                    w_state_nxt = S_IDLE;
                    if (r_op == c_op_digit) begin
                        if (int'(r_idx) < N_DIGITS) w_dig_we = 1'b1;
                        else                        w_err    = 1'b1;
                    end else begin
                        w_duty_we = 1'b1;
                    end
                end else if (r_tcnt == c_to_last) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge FPGA_clk) begin
        if (!FPGA_reset) begin
            r_op   <= 2'b00;
            r_idx  <= 2'b00;
            r_tcnt <= '0;
        end else if (w_latch) begin
            r_op   <= spi_data[3:2];
            r_idx  <= spi_data[1:0];
            r_tcnt <= '0;
        end else if (r_state == S_WAIT_PAYLOAD) begin
            r_tcnt <= r_tcnt + c_to_w'(1);
        end
    end

    // ---------------- digit storage ----------------
    always_comb begin
        w_dec = c_blank;
        case (spi_data)
            4'h0: w_dec = 7'h40;  4'h1: w_dec = 7'h79;
            4'h2: w_dec = 7'h24;  4'h3: w_dec = 7'h30;
            4'h4: w_dec = 7'h19;  4'h5: w_dec = 7'h12;
            4'h6: w_dec = 7'h02;  4'h7: w_dec = 7'h78;
            4'h8: w_dec = 7'h00;  4'h9: w_dec = 7'h10;
            4'hA: w_dec = 7'h08;  4'hB: w_dec = 7'h03;
            4'hC: w_dec = 7'h46;  4'hD: w_dec = 7'h21;
            4'hE: w_dec = 7'h06;  4'hF: w_dec = 7'h0E;
            default: w_dec = c_blank;
        endcase
    end

    always_ff @(posedge FPGA_clk) begin
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!FPGA_reset || w_clear)
                r_digit[i] <= c_blank;
            else if (w_dig_we && (r_idx == 2'(i)))
                r_digit[i] <= w_dec;
        end
    end

    // ---------------- PWM ----------------
    assign w_tick = &r_presc;
    assign w_wrap = w_tick && (r_pcnt == c_pwm_last);

    always_ff @(posedge FPGA_clk) begin
        if (!FPGA_reset) begin
            r_presc       <= '0;
            r_pcnt        <= 4'd0;
            r_duty_shadow <= 4'd0;
            r_duty_active <= 4'd0;
            r_pwm         <= 1'b0;
        end else begin
            r_presc <= r_presc + PWM_PRESC_W'(1);
            if (w_tick)
                r_pcnt <= (r_pcnt == c_pwm_last) ? 4'd0 : r_pcnt + 4'd1;
            if (w_duty_we)
                r_duty_shadow <= spi_data;
            // Shadow is transferred only at the period boundary so a new
            // duty never produces a truncated or stretched period.
            if (w_wrap)
                r_duty_active <= r_duty_shadow;
            r_pwm <= (r_pcnt < r_duty_active);
        end
    end

    // ---------------- display scan ----------------
    always_comb begin
        w_seg_sel = c_blank;
        w_en_sel  = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_scan_idx == c_idx_w'(i)) begin
                w_seg_sel   = r_digit[i];
                w_en_sel[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge FPGA_clk) begin
        if (!FPGA_reset) begin
            r_slot     <= '0;
            r_scan_idx <= '0;
            r_seg      <= c_blank;
            r_en       <= c_en_rst;
        end else begin
            if (r_slot == c_slot_last) begin
                r_slot     <= '0;
                r_scan_idx <= (r_scan_idx == c_idx_last) ? '0
                                                         : r_scan_idx + c_idx_w'(1);
            end else begin
                r_slot <= r_slot + c_slot_w'(1);
            end
            // Segments and enable come from the same index, so they move together.
            r_seg <= w_seg_sel;
            r_en  <= w_en_sel;
        end
    end

    always_ff @(posedge FPGA_clk) begin
        if (!FPGA_reset) r_frame_err <= 1'b0;
        else             r_frame_err <= w_err;
    end

    assign seg              = r_seg;
    assign digit_en_n       = r_en;
    assign motor_pwm_signal = r_pwm;
    assign duty_active      = r_duty_active;
    assign frame_err        = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_multidigit_pwm_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_multidigit_pwm_ctrl
// Description : Directed self-checking bench. dut1 is a 4-digit build,
//               dut2 a 2-digit build; both use short scan/PWM/timeout values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_multidigit_pwm_ctrl;

    logic       FPGA_clk   = 1'b0;
    logic       FPGA_reset = 1'b0;
    logic [3:0] spi_data   = 4'h0, spi_data2 = 4'h0;
    logic       spi_valid  = 1'b0, spi_valid2 = 1'b0;

    logic [6:0] seg, seg2;
    logic [3:0] digit_en_n;
    logic [1:0] digit_en_n2;
    logic       pwm, pwm2, ferr, ferr2;
    logic [3:0] duty, duty2;

    int n_tests = 0, n_fail = 0;
    int err_pulses = 0, err_run = 0, err_run_max = 0;
    logic err_prev = 1'b0;

    always #5 FPGA_clk = ~FPGA_clk;

    spi_multidigit_pwm_ctrl #(
        .N_DIGITS(4), .SCAN_DIV(4), .PWM_PRESC_W(2), .TIMEOUT_CYCLES(16)
    ) dut1 (
        .FPGA_clk(FPGA_clk), .FPGA_reset(FPGA_reset),
        .spi_data(spi_data), .spi_valid(spi_valid),
        .seg(seg), .digit_en_n(digit_en_n),
        .motor_pwm_signal(pwm), .duty_active(duty), .frame_err(ferr)
    );

    spi_multidigit_pwm_ctrl #(
        .N_DIGITS(2), .SCAN_DIV(4), .PWM_PRESC_W(2), .TIMEOUT_CYCLES(16)
    ) dut2 (
        .FPGA_clk(FPGA_clk), .FPGA_reset(FPGA_reset),
        .spi_data(spi_data2), .spi_valid(spi_valid2),
        .seg(seg2), .digit_en_n(digit_en_n2),
        .motor_pwm_signal(pwm2), .duty_active(duty2), .frame_err(ferr2)
    );

    // frame_err pulse counter for dut1, sampled mid-cycle
    always @(negedge FPGA_clk) begin
        if (ferr && !err_prev) err_pulses++;
        err_run = ferr ? err_run + 1 : 0;
        if (err_run > err_run_max) err_run_max = err_run;
        err_prev = ferr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge FPGA_clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d);
        spi_data  = d;
        spi_valid = 1'b1;
        tick(1);
        spi_valid = 1'b0;
    endtask

    task automatic send2(input logic [3:0] d);
        spi_data2  = d;
        spi_valid2 = 1'b1;
        tick(1);
        spi_valid2 = 1'b0;
    endtask

    // Wait for digit k to be scanned, then compare the shown segments.
    task automatic read_digit(input bit d2, input int k, input logic [6:0] exp, input string tag);
        logic [3:0] pat4;
        logic [1:0] pat2;
        bit found;
        pat4  = ~(4'b0001 << k);
        pat2  = ~(2'b01 << k);
        found = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            if (( d2 && digit_en_n2 == pat2) || (!d2 && digit_en_n == pat4)) found = 1'b1;
            else tick(1);
        end
        check({tag, "_scan"}, 32'(found), 32'd1);
        check(tag, d2 ? 32'(seg2) : 32'(seg), 32'(exp));
    endtask

    task automatic wait_duty(input logic [3:0] exp, input string tag);
        for (int c = 0; c < 80 && duty !== exp; c++) tick(1);
        check(tag, 32'(duty), 32'(exp));
    endtask

    task automatic count_high(input int n, input int exp, input string tag);
        int h;
        h = 0;
        for (int c = 0; c < n; c++) begin
            if (pwm) h++;
            tick(1);
        end
        check(tag, h, exp);
    endtask

    initial begin
        // ---- reset ----
        FPGA_reset = 1'b0;
        tick(3);
        FPGA_reset = 1'b1;
        check("rst_seg",  32'(seg),        32'h7F);
        check("rst_en",   32'(digit_en_n), 32'hE);
        check("rst_pwm",  32'(pwm),        32'd0);
        check("rst_duty", 32'(duty),       32'd0);
        check("rst_ferr", 32'(ferr),       32'd0);

        // ---- digit write, back-to-back header/payload ----
        send(4'b0010);
        send(4'h8);
        tick(2);
        read_digit(1'b0, 2, 7'h00, "dig2_8");
        read_digit(1'b0, 0, 7'h7F, "dig0_blank");
        read_digit(1'b0, 1, 7'h7F, "dig1_blank");
        read_digit(1'b0, 3, 7'h7F, "dig3_blank");

        // ---- duty 5 ----
        send(4'b0100);
        send(4'h5);
        check("duty_hold", 32'(duty), 32'd0);
        wait_duty(4'd5, "duty5");
        tick(2);
        count_high(60, 20, "pwm5_high");
        send(4'b0100);
        send(4'hF);
        wait_duty(4'd15, "duty15");
        tick(2);
        count_high(60, 60, "pwm15_high");
        send(4'b0100);
        send(4'h0);
        wait_duty(4'd0, "duty0");
        tick(2);
        count_high(60, 0, "pwm0_high");
        check("no_err_yet", err_pulses, 0);

        // ---- timeout ----
        send(4'b0001);
        tick(15);
        check("to_early", 32'(ferr), 32'd0);
        tick(1);
        check("to_pulse", 32'(ferr), 32'd1);
        tick(1);
        check("to_drop",  32'(ferr), 32'd0);
        send(4'h3);               // new header: digit 3, then also times out
        tick(20);
        check("to_pulses", err_pulses, 2);
        read_digit(1'b0, 1, 7'h7F, "to_dig1");
        read_digit(1'b0, 3, 7'h7F, "to_dig3");

        // ---- payload on exact expiry cycle ----
        send(4'b0001);
        tick(15);
        send(4'hA);
        check("exp_noerr", 32'(ferr), 32'd0);
        tick(2);
        check("exp_pulses", err_pulses, 2);
        read_digit(1'b0, 1, 7'h08, "exp_dig1");

        // ---- reserved op ----
        send(4'b1100);
        check("rsv_pulse", 32'(ferr), 32'd1);
        tick(1);
        check("rsv_drop",  32'(ferr), 32'd0);

        // ---- clear ----
        send(4'b0000);
        send(4'h1);
        tick(2);
        read_digit(1'b0, 0, 7'h79, "clr_pre0");
        send(4'b1000);
        tick(2);
        read_digit(1'b0, 0, 7'h7F, "clr_dig0");
        read_digit(1'b0, 1, 7'h7F, "clr_dig1");
        read_digit(1'b0, 2, 7'h7F, "clr_dig2");

        // ---- reset mid-frame / mid-period ----
        send(4'b0100);
        send(4'h7);
        wait_duty(4'd7, "duty7");
        send(4'b0001);
        FPGA_reset = 1'b0;
        tick(1);
        FPGA_reset = 1'b1;
        check("mrst_duty", 32'(duty), 32'd0);
        check("mrst_pwm",  32'(pwm),  32'd0);
        send(4'b0110);            // header (duty), not a digit-1 payload
        send(4'h9);
        wait_duty(4'd9, "mrst_duty9");
        read_digit(1'b0, 1, 7'h7F, "mrst_dig1");

        // ---- 2-digit build: out-of-range index ----
        send2(4'b0011);
        send2(4'h5);
        check("n2_err",  32'(ferr2), 32'd1);
        tick(1);
        check("n2_drop", 32'(ferr2), 32'd0);
        read_digit(1'b1, 0, 7'h7F, "n2_dig0");
        read_digit(1'b1, 1, 7'h7F, "n2_dig1");
        send2(4'b0001);
        send2(4'h7);
        check("n2_ok_noerr", 32'(ferr2), 32'd0);
        tick(2);
        read_digit(1'b1, 1, 7'h78, "n2_dig1_w");

        check("err_total",   err_pulses,  3);
        check("err_run_max", err_run_max, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
